apb_master_mc: RTL and testbench

- Parametrised next-generation APB4 requester: accepts single transfers on a valid/ready request channel and drives an APB bus shared by NUM_SLV completers.
- Each completer has its own PSEL; the completer is selected by address decode.
- Adds a response channel with backpressure, a per-transfer wait-state timeout and decode-error handling.
- Sits between an AXI4-Lite/CPU-side front end and the APB peripheral fabric.

---
 rtl/apb_mc_pkg.sv | 21 ++
 rtl/apb_mc_sel.sv | 41 ++++
 rtl/apb_master_mc.sv | 209 ++++++++++++++++++++
 tb/tb_apb_master_mc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mc_pkg.sv
// Shared types and width helpers for the multi-completer APB4 requester.
package apb_mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int PROT_W = 3;

    function automatic int idx_w(input int num_slv);
        return (num_slv <= 1) ? 1 : $clog2(num_slv);
    endfunction

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_mc_sel.sv
// Completer index decode (one-hot select, decode error) and response mux
// driven by the index of the transfer currently on the bus.
module apb_mc_sel
    import apb_mc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int IDX_W   = idx_w(NUM_SLV)
) (
    input  logic [IDX_W-1:0]          dec_idx_i,
    input  logic [IDX_W-1:0]          cur_idx_i,
    input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]        pready_i,
    input  logic [NUM_SLV-1:0]        pslverr_i,
    output logic [NUM_SLV-1:0]        onehot_o,
    output logic                      dec_err_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [DATA_W-1:0]         prdata_o
);

    localparam logic [IDX_W:0] NUM_SLV_L = (IDX_W + 1)'(NUM_SLV);

    assign dec_err_o = ({1'b0, dec_idx_i} >= NUM_SLV_L);

    always_comb begin
        onehot_o  = '0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            onehot_o[i] = (dec_idx_i == IDX_W'(i));
            if (cur_idx_i == IDX_W'(i)) begin
                pready_o  = pready_i[i];
                pslverr_o = pslverr_i[i];
                prdata_o  = prdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// APB4 requester for NUM_SLV completers: request/response channels, address
// decode, per-transfer ACCESS timeout and decode-error responses.
module apb_master_mc
    import apb_mc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [strb_w(DATA_W)-1:0]   req_strb,
    input  logic [PROT_W-1:0]           req_prot,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic [NUM_SLV-1:0]          psel,
    output logic                        penable,
    output logic [ADDR_W-1:0]           paddr,
    output logic                        pwrite,
    output logic [DATA_W-1:0]           pwdata,
    output logic [strb_w(DATA_W)-1:0]   pstrb,
    output logic [PROT_W-1:0]           pprot,
    input  logic [NUM_SLV*DATA_W-1:0]   prdata,
    input  logic [NUM_SLV-1:0]          pready,
    input  logic [NUM_SLV-1:0]          pslverr
);

    localparam int IDX_W  = idx_w(NUM_SLV);
    localparam int STRB_W = strb_w(DATA_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Both channels transfer on a rising edge where valid and ready are high;
    // valid, once raised, holds its payload stable until that edge.
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [PROT_W-1:0]   pprot_q, pprot_d;

    logic [NUM_SLV-1:0]  dec_onehot;
    logic                dec_err;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [DATA_W-1:0]   sel_prdata;

    apb_mc_sel #(
        .DATA_W  (DATA_W),
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_sel (
        .dec_idx_i (req_addr[SEL_LSB +: IDX_W]),
        .cur_idx_i (paddr_q[SEL_LSB +: IDX_W]),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr),
        .onehot_o  (dec_onehot),
        .dec_err_o (dec_err),
        .pready_o  (sel_pready),
        .pslverr_o (sel_pslverr),
        .prdata_o  (sel_prdata)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pwdata_d    = req_write ? req_wdata : '0;
                    pstrb_d     = req_write ? req_strb : '0;
                    pprot_d     = req_prot;
                    cnt_d       = '0;
                    if (dec_err) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d = SETUP;
                        psel_d  = dec_onehot;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // A pready in the final allowed cycle takes priority over the abort.
                if (sel_pready) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = sel_pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (pwrite_q || sel_pslverr) ? '0 : sel_prdata;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    req_ready_d   = 1'b1;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: 4-completer instance with TIMEOUT=8 and a
// 3-completer instance for decode errors; responses checked against exp_q.
module tb_apb_master_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-completer instance
    logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_prot = '0;
    logic        req_ready, rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic [3:0]  psel, pstrb;
    logic [2:0]  pprot;
    logic [127:0] prdata = '0;
    logic [3:0]  pready = '0, pslverr = '0;

    apb_master_mc #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // 3-completer instance: index 3 is unmapped
    logic        d3_req_valid = 1'b0, d3_rsp_ready = 1'b0;
    logic [31:0] d3_req_addr = '0;
    logic        d3_req_ready, d3_rsp_valid, d3_rsp_err, d3_rsp_timeout, d3_penable, d3_pwrite;
    logic [31:0] d3_rsp_rdata, d3_paddr, d3_pwdata;
    logic [2:0]  d3_psel;
    logic [3:0]  d3_pstrb;
    logic [2:0]  d3_pprot;

    apb_master_mc #(.DATA_W(32), .ADDR_W(32), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_write(1'b0),
        .req_addr(d3_req_addr), .req_wdata(32'h5555_AAAA), .req_strb(4'hF), .req_prot(3'b001),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_rdata(d3_rsp_rdata),
        .rsp_err(d3_rsp_err), .rsp_timeout(d3_rsp_timeout),
        .psel(d3_psel), .penable(d3_penable), .paddr(d3_paddr), .pwrite(d3_pwrite),
        .pwdata(d3_pwdata), .pstrb(d3_pstrb), .pprot(d3_pprot),
        .prdata({3{32'hFFFF_FFFF}}), .pready(3'b111), .pslverr(3'b000)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Completer model: selected slot answers per slv_*, others show inverted garbage.
    int          slv_wait = 0;
    logic        slv_never = 1'b0, slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt = 0;

    always @(negedge clk) begin
        if (psel != 0 && penable) begin
            pready = (!slv_never && acc_cnt == slv_wait) ? psel : ~psel;
            acc_cnt++;
        end else begin
            pready  = '0;
            acc_cnt = 0;
        end
        pslverr = slv_err ? psel : ~psel;
        for (int i = 0; i < 4; i++)
            prdata[i*32 +: 32] = psel[i] ? slv_rdata : ~slv_rdata;
    end

    logic [31:0] cur_addr, cur_wdata;
    logic        cur_wr;
    logic [3:0]  cur_strb;
    logic [2:0]  cur_prot;

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_strb = strb; req_prot = prot;
        cur_addr = addr; cur_wr = wr; cur_prot = prot;
        cur_wdata = wr ? wdata : 32'h0;
        cur_strb  = wr ? strb : 4'h0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = 4'($urandom_range(0, 15));
        req_write = ~wr;
    endtask

    // Follows one transfer from the cycle after acceptance to rsp_valid.
    task automatic wait_rsp(input logic [3:0] exp_sel, output int lat, output int acc_n);
        lat = 0;
        acc_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) check("setup_psel_penable", {psel, penable}, {exp_sel, 1'b0});
            if (k == 2) check("access_penable", {psel, penable}, {exp_sel, 1'b1});
            if (psel != 0 && penable) acc_n++;
            check("held_fields", {paddr, pwrite, pwdata, pstrb, pprot},
                  {cur_addr, cur_wr, cur_wdata, cur_strb, cur_prot});
            if (rsp_valid) begin
                lat = k;
                check("resp_bus_idle", {psel, penable}, 5'h0);
                break;
            end
        end
        if (lat == 0) check("rsp_valid_wait", 1'b0, 1'b1);
    endtask

    task automatic finish_rsp(input int hold);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1'b1, 1'b0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("rsp_payload", {rsp_err, rsp_timeout, rsp_rdata}, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rsp_hold", {rsp_valid, req_ready, rsp_err, rsp_timeout, rsp_rdata},
                  {1'b1, 1'b0, e});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_rsp_idle", {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int wt,
                        input logic err, input logic [31:0] rdata, input int hold);
        int lat, acc_n;
        logic [1:0] s;
        slv_wait = wt; slv_err = err; slv_rdata = rdata; slv_never = 1'b0;
        s = addr[13:12];
        exp_q.push_back({err, 1'b0, (!wr && !err) ? rdata : 32'h0});
        send(wr, addr, wdata, strb, prot);
        wait_rsp(4'b0001 << s, lat, acc_n);
        check("latency", lat, wt + 3);
        check("access_cycles", acc_n, wt + 1);
        finish_rsp(hold);
    endtask

    initial begin
        int lat, acc_n;
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel,
                                penable, paddr, pwrite, pwdata, pstrb, pprot}, 96'h0);
        check("reset_outputs_d3", {d3_req_ready, d3_rsp_valid, d3_psel, d3_penable, d3_paddr}, 38'h0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", {req_ready, d3_req_ready}, 2'b11);

        // zero-wait write to completer 2
        xfer(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0BAD_0BAD, 0);
        // read from completer 3 with 5 wait states
        xfer(1'b0, 32'h0000_3004, 32'h1111_2222, 4'hF, 3'b101, 5, 1'b0, 32'h1234_5678, 0);
        // pslverr from completer 0, response held off for 4 cycles
        xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000, 0, 1'b1, 32'hCAFE_F00D, 4);

        // completer 1 never ready: abort after 8 ACCESS cycles
        slv_never = 1'b1; slv_err = 1'b0; slv_rdata = 32'h7777_7777;
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        send(1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'h3, 3'b011);
        wait_rsp(4'b0010, lat, acc_n);
        check("timeout_access_cycles", acc_n, 8);
        check("timeout_latency", lat, 10);
        finish_rsp(0);
        // pready in the same cycle the counter expires wins
        xfer(1'b0, 32'h0000_1020, 32'h0, 4'h0, 3'b000, 7, 1'b0, 32'h0F0F_1234, 0);

        for (int n = 0; n < 8; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 255)) << 2);
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                 $urandom, $urandom_range(0, 2));
        end

        // decode error on the 3-completer instance
        @(negedge clk);
        check("d3_req_ready", d3_req_ready, 1'b1);
        d3_req_valid = 1'b1;
        d3_req_addr  = 32'h0000_3000;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        d3_req_valid = 1'b0;
        @(negedge clk);
        begin
            logic [33:0] e;
            e = exp_q.pop_front();
            check("d3_rsp_t1", {d3_rsp_valid, d3_rsp_err, d3_rsp_timeout, d3_rsp_rdata}, {1'b1, e});
        end
        check("d3_no_psel", {d3_psel, d3_penable, d3_req_ready}, 5'h0);
        d3_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        d3_rsp_ready = 1'b0;
        @(negedge clk);
        check("d3_post_rsp", {d3_rsp_valid, d3_req_ready, d3_psel}, 5'b01000);

        // reset during ACCESS of a read
        slv_never = 1'b1;
        send(1'b0, 32'h0000_3004, 32'h0, 4'h0, 3'b001);
        repeat (2) @(negedge clk);
        check("pre_reset_access", {psel, penable}, 5'b10001);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_xfer", {psel, penable, rsp_valid, req_ready}, 7'h0);
        rst = 1'b0;
        slv_never = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {req_ready, rsp_valid}, 2'b10);
        xfer(1'b1, 32'h0000_3ffc, 32'h0102_0304, 4'h5, 3'b110, 1, 1'b0, 32'h0, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
